// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer write stage.
package fb_pkg;

  localparam int DEFAULT_H_RES      = 640;
  localparam int DEFAULT_V_RES      = 480;
  localparam int DEFAULT_FIFO_DEPTH = 8;
  // Address width must cover H_RES*V_RES of the chosen geometry.
  localparam int ADDR_W             = 19;

  typedef struct packed {
    logic              white;
    logic [ADDR_W-1:0] addr;
  } pix_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } swap_state_t;

endpackage

// File: rtl/fb_write_stage_if.sv
// Pixel-in / framebuffer-out bundle of fb_write_stage; FB_STATS_EN adds the counter outputs.
interface fb_write_stage_if;
  import fb_pkg::*;

  // Both sides are valid/ready: a pixel moves when in_valid && in_ready, a write
  // completes when mem_we && mem_ready; mem_addr/mem_data hold while mem_we && !mem_ready.
  logic               in_valid;
  logic signed [10:0] in_x;
  logic signed [10:0] in_y;
  logic               in_white;
  logic               in_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_data;
  logic               mem_bank;
  logic               mem_ready;
  logic               disp_bank;
  logic               swap_pulse;
`ifdef FB_STATS_EN
  logic [15:0]        clip_count;
  logic [15:0]        write_count;
  logic [15:0]        last_clip;
  logic [15:0]        last_write;

  modport master (
    output in_valid, in_x, in_y, in_white, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_data, mem_bank, disp_bank, swap_pulse,
    input  clip_count, write_count, last_clip, last_write
  );
  modport slave (
    input  in_valid, in_x, in_y, in_white, mem_ready,
    output in_ready, mem_we, mem_addr, mem_data, mem_bank, disp_bank, swap_pulse,
    output clip_count, write_count, last_clip, last_write
  );
`else
  modport master (
    output in_valid, in_x, in_y, in_white, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_data, mem_bank, disp_bank, swap_pulse
  );
  modport slave (
    input  in_valid, in_x, in_y, in_white, mem_ready,
    output in_ready, mem_we, mem_addr, mem_data, mem_bank, disp_bank, swap_pulse
  );
`endif

endinterface

// File: rtl/fb_write_stage_pix_fifo.sv
// Synchronous FIFO of pix_t with a combinational head; push and pop may coincide when full.
module pix_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  pix_t        push_data,
  input  logic        pop,
  output pix_t        head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  pix_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fb_write_stage.sv
// Clips the pixel stream, linearises addresses, queues writes and swaps framebuffer banks on frame_clk.
// Optional macro FB_STATS_EN adds clip/write counters and their per-frame snapshots.
module fb_write_stage
  import fb_pkg::*;
#(
  parameter int H_RES      = DEFAULT_H_RES,
  parameter int V_RES      = DEFAULT_V_RES,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_clk,
  fb_write_stage_if.slave       bus,
  output swap_state_t           state_dbg
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W = $clog2(FIFO_DEPTH) + 2;
  localparam logic signed [10:0] X_LIM = 11'(H_RES);
  localparam logic signed [10:0] Y_LIM = 11'(V_RES);

  swap_state_t        state;
  swap_state_t        state_nxt;
  logic               bank_toggle;
  logic               draw_bank;
  logic               last_frame_clk;
  logic               frame_rise;
  logic               swap_pending;
  logic               pipe_empty;

  logic               accept;
  logic               in_range;
  logic               s1_valid;
  logic               s1_white;
  logic [10:0]        s1_x;
  logic [10:0]        s1_y;
  logic [ADDR_W-1:0]  addr_calc;
  logic               s2_valid;
  pix_t               s2_pix;

  pix_t               fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [CNT_W-1:0]   fifo_count;
  logic [INF_W-1:0]   inflight;

  // Input side: every occupied slot downstream of the port reserves a FIFO entry.
  assign inflight     = INF_W'(fifo_count) + INF_W'(s1_valid) + INF_W'(s2_valid);
  assign swap_pending = (state != RUN);
  assign bus.in_ready = !reset && !swap_pending && !fifo_full &&
                        (inflight < INF_W'(FIFO_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_range     = !bus.in_x[10] && (bus.in_x < X_LIM) &&
                        !bus.in_y[10] && (bus.in_y < Y_LIM);

  generate
    if (H_RES == 640) begin : g_addr_shift
      assign addr_calc = (ADDR_W'(s1_y) << 9) + (ADDR_W'(s1_y) << 7) + ADDR_W'(s1_x);
    end else begin : g_addr_mul
      assign addr_calc = ADDR_W'(s1_y) * ADDR_W'(H_RES) + ADDR_W'(s1_x);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_white <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s2_valid <= 1'b0;
      s2_pix   <= '0;
    end else begin
      s1_valid <= accept && in_range;
      if (accept) begin
        s1_x     <= bus.in_x;
        s1_y     <= bus.in_y;
        s1_white <= bus.in_white;
      end
      s2_valid     <= s1_valid;
      s2_pix.white <= s1_white;
      s2_pix.addr  <= addr_calc;
    end
  end

  pix_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s2_valid),
    .push_data (s2_pix),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The FIFO head is the write port; it stays put until mem_ready takes it.
  assign fifo_pop       = !fifo_empty && bus.mem_ready;
  assign bus.mem_we     = !fifo_empty;
  assign bus.mem_addr   = fifo_empty ? '0 : fifo_head.addr;
  assign bus.mem_data   = !fifo_empty && fifo_head.white;
  assign bus.mem_bank   = draw_bank;
  assign bus.disp_bank  = !draw_bank;
  assign bus.swap_pulse = (state == SWAP);

  assign frame_rise = frame_clk && !last_frame_clk;
  assign pipe_empty = !s1_valid && !s2_valid && fifo_empty;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      draw_bank      <= 1'b0;
      last_frame_clk <= 1'b0;
    end else begin
      state          <= state_nxt;
      last_frame_clk <= frame_clk;
      if (bank_toggle) draw_bank <= !draw_bank;
    end
  end

  // Edges seen outside RUN are dropped, so one frame tick yields at most one swap.
  always_comb begin
    state_nxt   = state;
    bank_toggle = 1'b0;
    case (state)
      RUN:     if (frame_rise) state_nxt = DRAIN;
      DRAIN: begin
        if (pipe_empty) begin
          state_nxt   = SWAP;
          bank_toggle = 1'b1;
        end
      end
      SWAP:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

`ifdef FB_STATS_EN
  logic [15:0] clip_q;
  logic [15:0] write_q;
  logic [15:0] last_clip_q;
  logic [15:0] last_write_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clip_q       <= '0;
      write_q      <= '0;
      last_clip_q  <= '0;
      last_write_q <= '0;
    end else if (state == SWAP) begin
      last_clip_q  <= clip_q;
      last_write_q <= write_q;
      clip_q       <= '0;
      write_q      <= '0;
    end else begin
      if (accept && !in_range && clip_q != 16'hFFFF) clip_q <= clip_q + 16'd1;
      if (fifo_pop && write_q != 16'hFFFF)           write_q <= write_q + 16'd1;
    end
  end

  assign bus.clip_count  = clip_q;
  assign bus.write_count = write_q;
  assign bus.last_clip   = last_clip_q;
  assign bus.last_write  = last_write_q;
`endif

endmodule

// File: tb/tb_fb_write_stage.sv
// Directed bench for fb_write_stage: expected writes queued at accept time, checked by a monitor.
module tb_fb_write_stage;
  import fb_pkg::*;

  localparam int EW = ADDR_W + 2;

  logic        clk;
  logic        reset;
  logic        frame_clk;
  swap_state_t state_dbg;

  fb_write_stage_if bus();

  fb_write_stage dut (
    .clk       (clk),
    .reset     (reset),
    .frame_clk (frame_clk),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  int swap_seen = 0;
  logic          exp_bank;
  logic [EW-1:0] exp_q[$];
  logic          stall_prev;
  logic [ADDR_W:0] stall_val;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] exp_entry(input int x, input int y, input bit w, input logic b);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(y * 640 + x);
    return {b, a, w};
  endfunction

  // Driver: offers one pixel until accepted, queues its expected write if on screen
  task automatic send_pix(input int x, input int y, input bit w);
    int waitc = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = 11'(x);
    bus.in_y     = 11'(y);
    bus.in_white = w;
    @(negedge clk);
    while (!bus.in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted", x, y);
    end else if (x >= 0 && x < 640 && y >= 0 && y < 480) begin
      exp_q.push_back(exp_entry(x, y, w, exp_bank));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || bus.mem_we) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!(bus.mem_we === 1'b1 && {bus.mem_addr, bus.mem_data} === stall_val)) begin
          errors++;
          $display("FAIL stall_hold: got we=%0d addr=%0d data=%0d expected addr=%0d data=%0d",
                   bus.mem_we, bus.mem_addr, bus.mem_data, stall_val[ADDR_W:1], stall_val[0]);
        end
      end
      if (bus.mem_we && bus.mem_ready) begin
        writes_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got bank=%0d addr=%0d data=%0d expected none",
                   bus.mem_bank, bus.mem_addr, bus.mem_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.mem_bank, bus.mem_addr, bus.mem_data} !== e) begin
            errors++;
            $display("FAIL write: got bank=%0d addr=%0d data=%0d expected bank=%0d addr=%0d data=%0d",
                     bus.mem_bank, bus.mem_addr, bus.mem_data, e[EW-1], e[ADDR_W:1], e[0]);
          end
        end
      end
      stall_prev = bus.mem_we && !bus.mem_ready;
      stall_val  = {bus.mem_addr, bus.mem_data};
      if (bus.swap_pulse) swap_seen++;
    end
  end

  initial begin
    int acc;
    int idx;
    int wb;
    reset         = 1'b1;
    frame_clk     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_white  = 1'b0;
    bus.mem_ready = 1'b1;
    exp_bank      = 1'b0;
    stall_prev    = 1'b0;
    stall_val     = '0;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_mem_we", 32'(bus.mem_we), 32'd0);
    check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset_mem_bank", 32'(bus.mem_bank), 32'd0);
    check("reset_disp_bank", 32'(bus.disp_bank), 32'd1);
    check("reset_swap_pulse", 32'(bus.swap_pulse), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.in_ready), 32'd1);
    tick();

    // Latency: accepted at edge c, visible on mem_we in cycle c+3
    send_pix(0, 0, 1'b1);
    @(negedge clk);
    check("lat_c1_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    check("lat_c2_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    check("lat_c3_we", 32'(bus.mem_we), 32'd1);
    check("lat_c3_addr", 32'(bus.mem_addr), 32'd0);
    check("lat_c3_data", 32'(bus.mem_data), 32'd1);
    check("lat_c3_bank", 32'(bus.mem_bank), 32'd0);
    tick();
    wait_drain("drain_first");

    // Corner pixel and clipped pixels
    send_pix(639, 479, 1'b1);
    send_pix(-1, 5, 1'b1);
    send_pix(640, 5, 1'b1);
    send_pix(5, 480, 1'b0);
    repeat (6) tick();
    wait_drain("drain_clip");
    check("clip_writes", 32'(writes_seen), 32'd2);
`ifdef FB_STATS_EN
    check("stat_clip", 32'(bus.clip_count), 32'd3);
    check("stat_write", 32'(bus.write_count), 32'd2);
`endif

    // Backpressure: stream 12 pixels into a stalled memory
    bus.mem_ready = 1'b0;
    acc = 0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 11'(10 + 50 * idx);
      bus.in_y     = 11'(200 + 3 * idx);
      bus.in_white = idx[0];
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(exp_entry(10 + 50 * idx, 200 + 3 * idx, idx[0], exp_bank));
        idx++;
        acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd8);
    repeat (3) tick();
    @(negedge clk);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_mem_we", 32'(bus.mem_we), 32'd1);
    tick();
    bus.mem_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_writes", 32'(writes_seen), 32'd10);

    // Swap with 4 writes queued, plus a second frame edge during DRAIN
    tick();
    bus.mem_ready = 1'b0;
    send_pix(1, 2, 1'b1);
    send_pix(2, 2, 1'b0);
    send_pix(3, 2, 1'b1);
    send_pix(4, 2, 1'b1);
    frame_clk = 1'b1;
    tick();
    @(negedge clk);
    check("drain_in_ready", 32'(bus.in_ready), 32'd0);
    check("drain_state", 32'(state_dbg), 32'(DRAIN));
    repeat (3) tick();
    frame_clk = 1'b0;
    tick();
    frame_clk = 1'b1;
    repeat (3) tick();
    check("no_swap_stalled", 32'(swap_seen), 32'd0);
    check("bank_held", 32'(bus.mem_bank), 32'd0);
    exp_bank = 1'b1;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 60 && swap_seen == 0; c++) @(negedge clk);
    repeat (5) tick();
    check("swap_once", 32'(swap_seen), 32'd1);
    check("swap_mem_bank", 32'(bus.mem_bank), 32'd1);
    check("swap_disp_bank", 32'(bus.disp_bank), 32'd0);
    check("swap_queue_empty", 32'(exp_q.size()), 32'd0);
    check("swap_writes", 32'(writes_seen), 32'd14);
`ifdef FB_STATS_EN
    check("stat_last_clip", 32'(bus.last_clip), 32'd3);
    check("stat_last_write", 32'(bus.last_write), 32'd14);
    check("stat_clip_clr", 32'(bus.clip_count), 32'd0);
    check("stat_write_clr", 32'(bus.write_count), 32'd0);
`endif
    frame_clk = 1'b0;
    send_pix(1, 1, 1'b1);
    wait_drain("bank1_write");

    // Reset with the FIFO partly filled: queued pixels are discarded
    tick();
    bus.mem_ready = 1'b0;
    send_pix(7, 7, 1'b1);
    send_pix(8, 7, 1'b1);
    send_pix(9, 7, 1'b1);
    send_pix(10, 7, 1'b1);
    repeat (2) tick();
    reset = 1'b1;
    exp_q.delete();
    exp_bank = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mid_mem_bank", 32'(bus.mem_bank), 32'd0);
    check("rst_mid_disp_bank", 32'(bus.disp_bank), 32'd1);
    check("rst_mid_state", 32'(state_dbg), 32'(RUN));
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    wb = writes_seen;
    repeat (10) tick();
    check("rst_mid_no_writes", 32'(writes_seen), 32'(wb));
    send_pix(639, 0, 1'b0);
    wait_drain("post_reset_write");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
